// File: rtl/tag_lookup_ctrl.sv
// tag_lookup_ctrl: initiator-side controller for a direct-mapped cache tag RAM.
// Splits each lookup address into tag/index/offset, reads the external tag RAM
// (one-cycle registered read), checks it against local per-set valid bits and
// reports hit or miss. A miss issues a line refill, waits for completion, then
// writes the new tag and marks the set valid.
// Optional feature macro: TAG_LOOKUP_STATS_EN adds saturating hit/miss counters.

module tag_lookup_ctrl #(
    parameter int  ENTRIES  = 256,
    parameter int  ADDR_W   = 32,
    parameter int  OFFSET_W = 4,
    localparam int IDX_W    = $clog2(ENTRIES),
    localparam int TAG_W    = ADDR_W - IDX_W - OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              fill_req_valid,
    input  logic              fill_req_ready,
    output logic [ADDR_W-1:0] fill_req_addr,
    input  logic              fill_done,
    input  logic              inv_all,
    output logic [IDX_W-1:0]  ram_addr,
    output logic              ram_wr,
    output logic [TAG_W-1:0]  ram_tag_in,
    input  logic [TAG_W-1:0]  ram_tag_out
`ifdef TAG_LOOKUP_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int LINE_W = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        UPDATE
    } state_e;

    state_e              state_q;
    logic [LINE_W-1:0]   line_q;         // latched request address without offset
    logic [IDX_W-1:0]    ram_addr_q;
    logic [ENTRIES-1:0]  valid_q;
    logic                inv_pending_q;
    logic                resp_valid_q;
    logic                resp_hit_q;
    logic                fill_req_valid_q;
    logic [ADDR_W-1:0]   fill_req_addr_q;
    logic                ram_wr_q;
    logic [TAG_W-1:0]    ram_tag_in_q;

    logic [LINE_W-1:0]   req_line;
    logic [TAG_W-1:0]    cur_tag;
    logic [IDX_W-1:0]    cur_idx;
    logic                inv_now;
    logic                accept;
    logic                lookup_hit;
    logic                unused_offset;

    assign req_line      = req_addr[ADDR_W-1:OFFSET_W];
    // Byte offset within the line plays no part in the lookup.
    assign unused_offset = ^req_addr[OFFSET_W-1:0];
    assign cur_tag       = line_q[LINE_W-1:IDX_W];
    assign cur_idx       = line_q[IDX_W-1:0];

    // A same-cycle inv_all counts as pending so invalidation beats a new request.
    assign inv_now    = inv_pending_q | inv_all;
    assign req_ready  = (state_q == IDLE) && !inv_now;
    assign accept     = req_valid && req_ready;

    // The index goes to the RAM in the accept cycle so the tag is back in LOOKUP.
    assign ram_addr   = accept ? req_line[IDX_W-1:0] : ram_addr_q;
    assign lookup_hit = valid_q[cur_idx] && (ram_tag_out == cur_tag);

    assign resp_valid     = resp_valid_q;
    assign resp_hit       = resp_hit_q;
    assign fill_req_valid = fill_req_valid_q;
    assign fill_req_addr  = fill_req_addr_q;
    assign ram_wr         = ram_wr_q;
    assign ram_tag_in     = ram_tag_in_q;

    // Control FSM with registered outputs, valid bits and sticky invalidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            line_q           <= '0;
            ram_addr_q       <= '0;
            // NOTE: valid bits are plain flops, not a RAM, so they can and must
            // be cleared by reset; the tag RAM contents never need resetting.
            valid_q          <= '0;
            inv_pending_q    <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_hit_q       <= 1'b0;
            fill_req_valid_q <= 1'b0;
            fill_req_addr_q  <= '0;
            ram_wr_q         <= 1'b0;
            ram_tag_in_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment in
            // the case below overrides these single-cycle defaults.
            resp_valid_q  <= 1'b0;
            ram_wr_q      <= 1'b0;
            inv_pending_q <= inv_pending_q | inv_all;

            case (state_q)
                IDLE: begin
                    if (inv_now) begin
                        valid_q       <= '0;
                        inv_pending_q <= 1'b0;
                    end else if (req_valid) begin
                        line_q     <= req_line;
                        ram_addr_q <= req_line[IDX_W-1:0];
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        fill_req_valid_q <= 1'b1;
                        fill_req_addr_q  <= {line_q, {OFFSET_W{1'b0}}};
                        state_q          <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (fill_req_ready) begin
                        fill_req_valid_q <= 1'b0;
                        state_q          <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (fill_done) begin
                        ram_wr_q     <= 1'b1;
                        ram_tag_in_q <= cur_tag;
                        state_q      <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid_q[cur_idx] <= 1'b1;
                    resp_valid_q     <= 1'b1;
                    resp_hit_q       <= 1'b0;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef TAG_LOOKUP_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;
    logic [31:0] hit_count_d;
    logic [31:0] miss_count_d;

    // Next-count logic: one increment per response, holding at all-ones.
    always_comb begin
        // NOTE: defaults first so every path assigns both, avoiding latches.
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (resp_valid_q) begin
            if (resp_hit_q && (hit_count_q != '1)) begin
                hit_count_d = hit_count_q + 32'd1;
            end
            if (!resp_hit_q && (miss_count_q != '1)) begin
                miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    // Counter registers; only reset clears them, inv_all leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
